// File: rtl/capture_ctrl.sv
// Capture controller for a single-port 2048x8 sample BRAM: circular pre-trigger capture,
// masked trigger, post-trigger capture, then valid/ready readout of the captured window.
module capture_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              arm,
    input  logic              abort,
    input  logic [DATA_W-1:0] probe,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [ADDR_W-1:0] pre_count,
    input  logic [ADDR_W-1:0] post_count,
    input  logic              rd_start,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRE    = 3'd1,
        S_WAIT   = 3'd2,
        S_POST   = 3'd3,
        S_DONE   = 3'd4,
        S_READ_A = 3'd5,
        S_READ_D = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    state_t            state_r, state_s;
    logic [DATA_W-1:0] probe_r;
    logic [ADDR_W-1:0] wr_ptr_r, wr_ptr_s, rd_ptr_r, rd_ptr_s, rd_idx_r, rd_idx_s;
    logic [ADDR_W-1:0] cnt_r, cnt_s, pre_eff_r, pre_eff_s, post_r, post_s;
    logic [ADDR_W-1:0] trig_addr_s, arm_pre_s, last_idx_s;
    logic              triggered_s, match_s, wr_phase_s;

    function automatic logic trig_hit(input logic [DATA_W-1:0] smp,
                                      input logic [DATA_W-1:0] val,
                                      input logic [DATA_W-1:0] msk);
        return (((smp ^ val) & msk) == DATA_ZERO);
    endfunction

    // Next-state and next-pointer logic; registered outputs are derived from these.
    always_comb begin
        state_s     = state_r;
        wr_ptr_s    = wr_ptr_r;
        rd_ptr_s    = rd_ptr_r;
        rd_idx_s    = rd_idx_r;
        cnt_s       = cnt_r;
        pre_eff_s   = pre_eff_r;
        post_s      = post_r;
        trig_addr_s = trig_addr;
        triggered_s = triggered;
        match_s     = trig_hit(probe_r, trig_value, trig_mask);
        // DEPTH-1-post_count is simply the bitwise complement of post_count.
        arm_pre_s   = (pre_count < ~post_count) ? pre_count : ~post_count;

        if (abort) begin
            state_s     = S_IDLE;
            triggered_s = 1'b0;
        end else if (arm && (state_r == S_IDLE || state_r == S_DONE)) begin
            state_s     = (arm_pre_s == ADDR_ZERO) ? S_WAIT : S_PRE;
            wr_ptr_s    = ADDR_ZERO;
            cnt_s       = ADDR_ZERO;
            triggered_s = 1'b0;
            pre_eff_s   = arm_pre_s;
            post_s      = post_count;
        end else begin
            case (state_r)
                S_IDLE: state_s = S_IDLE;
                S_PRE: begin
                    wr_ptr_s = wr_ptr_r + ADDR_ONE;
                    cnt_s    = cnt_r + ADDR_ONE;
                    state_s  = (cnt_s == pre_eff_r) ? S_WAIT : S_PRE;
                end
                S_WAIT: begin
                    wr_ptr_s = wr_ptr_r + ADDR_ONE;
                    if (match_s) begin
                        trig_addr_s = wr_ptr_r;
                        triggered_s = 1'b1;
                        cnt_s       = ADDR_ZERO;
                        state_s     = (post_r == ADDR_ZERO) ? S_DONE : S_POST;
                    end else begin
                        state_s = S_WAIT;
                    end
                end
                S_POST: begin
                    wr_ptr_s = wr_ptr_r + ADDR_ONE;
                    cnt_s    = cnt_r + ADDR_ONE;
                    state_s  = (cnt_s == post_r) ? S_DONE : S_POST;
                end
                S_DONE: begin
                    if (rd_start) begin
                        state_s  = S_READ_A;
                        rd_ptr_s = trig_addr - pre_eff_r;
                        rd_idx_s = ADDR_ZERO;
                    end else begin
                        state_s = S_DONE;
                    end
                end
                S_READ_A: state_s = S_READ_D;
                S_READ_D: begin
                    if (rd_ready) begin
                        rd_ptr_s = rd_ptr_r + ADDR_ONE;
                        rd_idx_s = rd_idx_r + ADDR_ONE;
                        state_s  = (rd_idx_r == pre_eff_r + post_r) ? S_IDLE : S_READ_A;
                    end else begin
                        state_s = S_READ_D;
                    end
                end
                default: state_s = S_IDLE;
            endcase
        end

        wr_phase_s = (state_s == S_PRE) || (state_s == S_WAIT) || (state_s == S_POST);
        last_idx_s = pre_eff_s + post_s;
    end

    // State, pointers and all outputs registered from the next-state view.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r    <= S_IDLE;
            probe_r    <= DATA_ZERO;
            wr_ptr_r   <= ADDR_ZERO;
            rd_ptr_r   <= ADDR_ZERO;
            rd_idx_r   <= ADDR_ZERO;
            cnt_r      <= ADDR_ZERO;
            pre_eff_r  <= ADDR_ZERO;
            post_r     <= ADDR_ZERO;
            trig_addr  <= ADDR_ZERO;
            triggered  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            bram_en    <= 1'b0;
            bram_we    <= 1'b0;
            bram_addr  <= ADDR_ZERO;
            bram_wdata <= DATA_ZERO;
        end else begin
            state_r    <= state_s;
            probe_r    <= probe;
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            rd_idx_r   <= rd_idx_s;
            cnt_r      <= cnt_s;
            pre_eff_r  <= pre_eff_s;
            post_r     <= post_s;
            trig_addr  <= trig_addr_s;
            triggered  <= triggered_s;
            busy       <= wr_phase_s || (state_s == S_READ_A) || (state_s == S_READ_D);
            done       <= (state_s == S_DONE);
            rd_valid   <= (state_s == S_READ_D);
            rd_last    <= (state_s == S_READ_D) && (rd_idx_s == last_idx_s);
            bram_en    <= wr_phase_s || (state_s == S_READ_A);
            bram_we    <= wr_phase_s;
            bram_addr  <= (state_s == S_READ_A) ? rd_ptr_s : (wr_phase_s ? wr_ptr_s : ADDR_ZERO);
            // The write issued next cycle carries the sample registered into probe_r at this edge.
            bram_wdata <= wr_phase_s ? probe : DATA_ZERO;
        end
    end

    // The BRAM output register already holds the sample steady while EN is low.
    assign rd_data = rd_valid ? bram_rdata : DATA_ZERO;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: table of capture/readout scenarios with a behavioural
// 2048x8 BRAM, plus hand-written abort, reset and ignored-pulse sequences.
module tb_capture_ctrl;

    logic        CLK, RST, arm, abort, rd_start, rd_ready;
    logic [7:0]  probe, trig_mask, trig_value, rd_data, bram_wdata;
    logic [7:0]  bram_rdata;
    logic [10:0] pre_count, post_count, trig_addr, bram_addr;
    logic        rd_valid, rd_last, busy, triggered, done, bram_en, bram_we;

    int n_checks;
    int n_pass;

    logic [7:0] mem [0:2047];

    typedef struct {
        int         pre;
        int         post;
        logic [7:0] mask;
        logic [7:0] value;
        int         exp_trig;
        int         exp_len;
        int         exp_first;
        int         rearm_step;
        bit         toggle;
        bit         do_read;
    } vec_t;

    vec_t vecs [6];

    capture_ctrl dut (
        .CLK(CLK), .RST(RST), .arm(arm), .abort(abort), .probe(probe),
        .trig_mask(trig_mask), .trig_value(trig_value),
        .pre_count(pre_count), .post_count(post_count),
        .rd_start(rd_start), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_last(rd_last), .busy(busy),
        .triggered(triggered), .done(done), .trig_addr(trig_addr),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single-port BRAM, 1-cycle read latency, output held while EN is low
    initial bram_rdata = 8'h00;
    always @(posedge CLK) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_wdata;
            else         bram_rdata <= mem[bram_addr];
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    endtask

    task automatic capture(input vec_t v, input string tag);
        int step;
        int cyc;
        pre_count  = 11'(v.pre);
        post_count = 11'(v.post);
        trig_mask  = v.mask;
        trig_value = v.value;
        step  = 0;
        probe = 8'h00;
        arm   = 1'b1;
        tick();
        arm = 1'b0;
        check({tag, "_busy_after_arm"}, busy, 1);
        cyc = 0;
        while (!done && cyc < 6000) begin
            step++;
            probe = step[7:0];
            arm   = (v.rearm_step != 0 && step == v.rearm_step);
            tick();
            cyc++;
        end
        arm = 1'b0;
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_in_done"}, busy, 0);
        check({tag, "_triggered"}, triggered, 1);
        check({tag, "_trig_addr"}, trig_addr, v.exp_trig);
        check({tag, "_bram_en_in_done"}, bram_en, 0);
    endtask

    task automatic readout(input int n, input int first, input bit toggle, input string tag);
        int         got, cyc, data_bad, last_bad, stall_bad, we_bad;
        bit         stalled;
        logic [7:0] held, exp;
        got = 0; cyc = 0; data_bad = 0; last_bad = 0; stall_bad = 0; we_bad = 0;
        stalled = 1'b0;
        held = 8'h00;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        while (got < n && cyc < 14000) begin
            rd_ready = toggle ? (cyc % 3 != 0) : 1'b1;
            if (bram_en && bram_we) we_bad++;
            if (rd_valid) begin
                if (rd_last != (got == n - 1)) last_bad++;
                if (stalled && rd_data != held) stall_bad++;
                if (rd_ready) begin
                    exp = 8'(first + got);
                    if (rd_data != exp) begin
                        if (data_bad == 0)
                            $display("  %s sample %0d: got %02h want %02h", tag, got, rd_data, exp);
                        data_bad++;
                    end
                    got++;
                    stalled = 1'b0;
                end else begin
                    held    = rd_data;
                    stalled = 1'b1;
                end
            end
            tick();
            cyc++;
        end
        rd_ready = 1'b1;
        check({tag, "_samples_accepted"}, got, n);
        check({tag, "_data_errors"}, data_bad, 0);
        check({tag, "_last_errors"}, last_bad, 0);
        check({tag, "_stall_changes"}, stall_bad, 0);
        check({tag, "_write_during_read"}, we_bad, 0);
        check({tag, "_valid_after_last"}, rd_valid, 0);
        check({tag, "_done_after_last"}, done, 0);
        check({tag, "_busy_after_last"}, busy, 0);
    endtask

    initial begin
        int cyc;
        n_checks = 0;
        n_pass   = 0;
        RST = 1'b1; arm = 1'b0; abort = 1'b0; rd_start = 1'b0; rd_ready = 1'b1;
        probe = 8'h00; trig_mask = 8'h00; trig_value = 8'h00;
        pre_count = 11'd0; post_count = 11'd0;

        vecs[0] = '{pre:4,    post:3,   mask:8'hFF, value:8'hA5, exp_trig:165, exp_len:8,    exp_first:161, rearm_step:0,  toggle:1'b0, do_read:1'b1};
        vecs[1] = '{pre:4,    post:3,   mask:8'hFF, value:8'hA5, exp_trig:165, exp_len:8,    exp_first:161, rearm_step:50, toggle:1'b1, do_read:1'b1};
        vecs[2] = '{pre:0,    post:0,   mask:8'hFF, value:8'h07, exp_trig:7,   exp_len:1,    exp_first:7,   rearm_step:0,  toggle:1'b0, do_read:1'b0};
        vecs[3] = '{pre:10,   post:3,   mask:8'h00, value:8'h00, exp_trig:10,  exp_len:14,   exp_first:0,   rearm_step:0,  toggle:1'b0, do_read:1'b1};
        vecs[4] = '{pre:5,    post:2,   mask:8'hF0, value:8'h30, exp_trig:48,  exp_len:8,    exp_first:43,  rearm_step:0,  toggle:1'b1, do_read:1'b1};
        vecs[5] = '{pre:2000, post:100, mask:8'hFF, value:8'h00, exp_trig:0,   exp_len:2048, exp_first:101, rearm_step:0,  toggle:1'b0, do_read:1'b1};

        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_triggered", triggered, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_last", rd_last, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_trig_addr", trig_addr, 0);
        check("rst_bram_en", bram_en, 0);
        check("rst_bram_we", bram_we, 0);
        check("rst_bram_addr", bram_addr, 0);
        check("rst_bram_wdata", bram_wdata, 0);
        RST = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            capture(vecs[i], tag);
            if (vecs[i].do_read) readout(vecs[i].exp_len, vecs[i].exp_first, vecs[i].toggle, tag);
        end

        // abort during POST returns to IDLE with everything cleared next cycle
        pre_count = 11'd4; post_count = 11'd50; trig_mask = 8'hFF; trig_value = 8'h20;
        probe = 8'h00; arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int s = 1; s <= 40; s++) begin
            probe = 8'(s);
            tick();
        end
        check("post_triggered", triggered, 1);
        check("post_busy", busy, 1);
        check("post_trig_addr", trig_addr, 32);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_triggered", triggered, 0);
        check("abort_bram_en", bram_en, 0);
        check("abort_rd_valid", rd_valid, 0);

        // abort beats arm; rd_start outside DONE does nothing
        arm = 1'b1; abort = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b0;
        check("abort_vs_arm_busy", busy, 0);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        check("rdstart_idle_valid", rd_valid, 0);
        check("rdstart_idle_bram_en", bram_en, 0);

        // RST asserted mid-READ_D clears outputs immediately
        capture(vecs[0], "rstseq");
        rd_ready = 1'b0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        cyc = 0;
        while (!rd_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        check("rstseq_in_read_d", rd_valid, 1);
        check("rstseq_first_sample", rd_data, 8'hA1);
        #2 RST = 1'b1;
        #1;
        check("rstseq_rd_valid", rd_valid, 0);
        check("rstseq_bram_en", bram_en, 0);
        check("rstseq_done", done, 0);
        check("rstseq_busy", busy, 0);
        check("rstseq_triggered", triggered, 0);
        tick();
        RST = 1'b0;
        rd_ready = 1'b1;
        tick();
        check("rstseq_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
